// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
//
// Purpose: steps one instruction at a time through FETCH, DECODE, an execute
// or address state, an optional memory-wait state and writeback. Each
// memory wait is bounded by MEM_TIMEOUT cycles, after which the block parks
// in FAULT until reset.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   instruction       IR contents (class in [31:29], ALU op in [28:24], store bit [24])
//   mem_ready         single-cycle memory completion pulse
//   zero              ALU zero flag, used in BRANCH
//   pc_write, ir_write, i_or_d, mem_read_n, mem_write_n, alu_src, alu_op,
//   reg_write, mem_to_reg, branch
//                     datapath controls
//   illegal           one-cycle pulse on an unknown instruction class
//   fault             memory-timeout indicator (held while in FAULT)
//   state             current FSM state
//   retired           wrapping count of retired instructions

module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read_n,
  output logic               mem_write_n,
  output logic               alu_src,
  output logic [4:0]         alu_op,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               branch,
  output logic               illegal,
  output logic               fault,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_ALU  = 4'd2,
    S_WB_ALU    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_LOAD  = 4'd5,
    S_WB_LOAD   = 4'd6,
    S_MEM_STORE = 4'd7,
    S_BRANCH    = 4'd8,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);
  localparam logic [COUNT_W-1:0] RET_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         tmo_q, tmo_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               wait_st;
  logic               timed_out;

  // Only the class, opcode and store-select fields steer the sequencer.
  logic unused_instr;
  assign unused_instr = ^instruction[23:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    retired_d   = retired_q;
    wait_st     = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read_n  = 1'b1;
    mem_write_n = 1'b1;
    alu_src     = 1'b0;
    alu_op      = 5'b00000;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    fault       = 1'b0;
    // This cycle would be the MEM_TIMEOUT-th one without mem_ready.
    timed_out   = ({1'b0, tmo_q} + 9'd1) >= TMO_LIMIT;

    // While reset is held the state already reads FETCH, but the outputs
    // stay idle so no strobe fires before reset is released.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          wait_st    = 1'b1;
          mem_read_n = 1'b0;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timed_out) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          case (instruction[31:29])
            3'b100:  state_d = S_EXEC_ALU;
            3'b001:  state_d = S_MEM_ADDR;
            3'b010:  state_d = S_BRANCH;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC_ALU: begin
          alu_op  = instruction[28:24];
          state_d = S_WB_ALU;
        end
        S_WB_ALU: begin
          alu_op    = instruction[28:24];
          reg_write = 1'b1;
          retired_d = retired_q + RET_ONE;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src = 1'b1;
          state_d = instruction[24] ? S_MEM_STORE : S_MEM_LOAD;
        end
        S_MEM_LOAD: begin
          wait_st    = 1'b1;
          i_or_d     = 1'b1;
          alu_src    = 1'b1;
          mem_read_n = 1'b0;
          if (mem_ready) begin
            state_d = S_WB_LOAD;
          end else if (timed_out) begin
            state_d = S_FAULT;
          end
        end
        S_WB_LOAD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retired_d  = retired_q + RET_ONE;
          state_d    = S_FETCH;
        end
        S_MEM_STORE: begin
          wait_st     = 1'b1;
          i_or_d      = 1'b1;
          alu_src     = 1'b1;
          mem_write_n = 1'b0;
          if (mem_ready) begin
            retired_d = retired_q + RET_ONE;
            state_d   = S_FETCH;
          end else if (timed_out) begin
            state_d = S_FAULT;
          end
        end
        S_BRANCH: begin
          alu_op    = 5'b00001;
          branch    = zero;
          pc_write  = zero;
          retired_d = retired_q + RET_ONE;
          state_d   = S_FETCH;
        end
        S_FAULT: begin
          fault = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase

      // Count only while still waiting in the same state; any exit or
      // mem_ready leaves the counter cleared for the next wait.
      if (wait_st && !mem_ready && (state_d == state_q)) begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the Lapido datapath. It replaces single-step decode with an FSM that drives fetch, decode, execute, memory and writeback over several cycles.
- Handshakes with instruction/data memory through mem_ready and has a per-access timeout.
- Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register, ALU, register file and memory port.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in any memory-wait state without mem_ready before entering FAULT; legal range 1..255.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  IR contents; stable from the cycle after ir_write.
- mem_ready  in  1  memory access complete, single-cycle pulse; ignored outside wait states.
- zero  in  1  ALU zero flag, combinational, valid in BRANCH.
- pc_write  out  1  load PC (PC+4, or branch target when branch=1).
- ir_write  out  1  capture memory data into IR.
- i_or_d  out  1  address mux select: 0=PC, 1=ALU result.
- mem_read_n  out  1  memory read strobe, active-low.
- mem_write_n  out  1  memory write strobe, active-low.
- alu_src  out  1  ALU B select: 0=register, 1=immediate.
- alu_op  out  5  ALU operation code.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback select: 0=ALU, 1=memory.
- branch  out  1  PC source: branch target.
- illegal  out  1  one-cycle pulse on an unknown instruction class.
- fault  out  1  sticky memory-timeout indicator.
- state  out  4  current FSM state, for debug.
- retired  out  COUNT_W  count of retired instructions; wraps modulo 2^COUNT_W.

Behaviour:
- Reset, asynchronous and at any point mid-operation:
  - state=FETCH, retired=0, timeout counter=0, fault=0.
  - All enables 0, mem_read_n=mem_write_n=1, alu_op=00000.
- Output timing: outputs are Moore decodes of state. Exceptions are pc_write/ir_write (gated by mem_ready) and branch/pc_write in BRANCH (gated by zero).
- States and transitions:
  - FETCH: i_or_d=0, mem_read_n=0. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - DECODE: one cycle, no enables. Classify instruction[31:29]:
    - 100 -> EXEC_ALU.
    - 001 -> MEM_ADDR.
    - 010 -> BRANCH.
    - any other value -> illegal=1 for this cycle, return to FETCH. Not counted as retired.
  - EXEC_ALU: alu_src=0, alu_op=instruction[28:24] -> WB_ALU.
  - WB_ALU: alu_op held, reg_write=1, mem_to_reg=0, retired+1 -> FETCH.
  - MEM_ADDR: alu_src=1, alu_op=00000 (add). If instruction[24]=0 go to MEM_LOAD, else MEM_STORE.
  - MEM_LOAD: i_or_d=1, alu_src=1, alu_op=00000, mem_read_n=0 until mem_ready -> WB_LOAD.
  - WB_LOAD: reg_write=1, mem_to_reg=1 -> FETCH, retired+1.
  - MEM_STORE: i_or_d=1, alu_src=1, alu_op=00000, mem_write_n=0 until mem_ready -> FETCH, retired+1.
  - BRANCH: alu_src=0, alu_op=00001 (sub). If zero=1: branch=1, pc_write=1. Always -> FETCH, retired+1.
  - FAULT: all enables 0, strobes 1, fault=1. Exit only via reset.
- Memory-wait timeout (FETCH, MEM_LOAD, MEM_STORE):
  - Timeout counter clears on entry to each wait state and on mem_ready.
  - It increments every cycle without mem_ready.
  - When the count reaches MEM_TIMEOUT with mem_ready still low, next state is FAULT.
  - mem_ready in the same cycle as the count reaching MEM_TIMEOUT wins: normal transition.
- Latency with zero-wait memory (mem_ready high in the first wait cycle):
  - ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Illegal: 2 cycles.
- retired at all-ones wraps to 0 on the next retirement.
- Strobe limits: mem_read_n and mem_write_n are never both 0. No memory strobe is active in DECODE, EXEC_ALU, WB_*, MEM_ADDR, BRANCH or FAULT.
- State encoding, 4 bits: FETCH=0, DECODE=1, EXEC_ALU=2, WB_ALU=3, MEM_ADDR=4, MEM_LOAD=5, WB_LOAD=6, MEM_STORE=7, BRANCH=8, FAULT=15.

Test Plan:
- ALU instruction 0x82000000, mem_ready immediate: states 0,1,2,3. alu_op=00010 in states 2–3, reg_write=1 in state 3, retired 0->1.
- Load 0x20000000, mem_ready 3 cycles after MEM_LOAD entry: mem_read_n=0 and i_or_d=1 for 3 cycles. WB_LOAD asserts reg_write=1, mem_to_reg=1.
- Store 0x21000000: mem_write_n=0 in MEM_STORE, mem_read_n stays 1, reg_write never 1, retired increments on return to FETCH.
- Branch 0x40000000: with zero=1, branch=1 and pc_write=1 for one cycle; with zero=0, both stay 0. Back to FETCH either way.
- Unknown class 0xE0000000: illegal pulses one cycle in DECODE, retired unchanged. mem_ready held 0 for 15 cycles in FETCH -> FAULT, fault=1.
- Assert reset mid-MEM_LOAD: state=0 and mem_read_n=1 immediately, without waiting for a clock edge. retired=0, fault cleared.
